muldiv_seq: RTL and testbench

- Iterative multiply/divide sequencer in the EX stage, beside the single-cycle ALU.
- Executes RV32M MUL/DIV/DIVU/REM/REMU over multiple cycles.
- Holds the pipeline through stall_o until the result is ready.
- Decode raises start_i when ALUOp = 2'b10 and funct7 = 0000001.

---
 rtl/muldiv_seq_pkg.sv | 10 +
 rtl/muldiv_seq_if.sv | 20 ++
 rtl/muldiv_seq_core.sv | 27 ++
 rtl/muldiv_seq.sv | 85 ++++++++
 tb/tb_muldiv_seq.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_seq_pkg.sv
// muldiv_seq_pkg: shared RV32M funct3 codes, FSM state encoding and default width
package muldiv_seq_pkg;
    localparam int W_DEF = 32;
    localparam logic [2:0] F3_MUL  = 3'b000;
    localparam logic [2:0] F3_DIV  = 3'b100;
    localparam logic [2:0] F3_DIVU = 3'b101;
    localparam logic [2:0] F3_REM  = 3'b110;
    localparam logic [2:0] F3_REMU = 3'b111;
    typedef enum logic [1:0] {IDLE = 2'd0, CALC = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/muldiv_seq_if.sv
// muldiv_seq_if: request/response bundle between decode/EX pipeline and the sequencer
interface muldiv_seq_if
    import muldiv_seq_pkg::*;
#(
    parameter int WIDTH = W_DEF
) ();
    logic             start_i;
    logic [2:0]       func3_i;
    logic [WIDTH-1:0] src1_i;
    logic [WIDTH-1:0] src2_i;
    logic             flush_i;
    logic             busy_o;
    logic             stall_o;
    logic             done_o;
    logic [WIDTH-1:0] result_o;
    modport master (output start_i, func3_i, src1_i, src2_i, flush_i,
                    input  busy_o, stall_o, done_o, result_o);
    modport slave  (input  start_i, func3_i, src1_i, src2_i, flush_i,
                    output busy_o, stall_o, done_o, result_o);
endinterface

// File: rtl/muldiv_seq_core.sv
// muldiv_core: one combinational iteration of shift-add multiply or restoring divide
module muldiv_core
    import muldiv_seq_pkg::*;
#(
    parameter int WIDTH = W_DEF
) (
    input  logic             mul,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    output logic [WIDTH-1:0] acc_n,
    output logic [WIDTH-1:0] opa_n,
    output logic [WIDTH-1:0] opb_n
);
    logic [WIDTH:0]   sh;
    logic [WIDTH-1:0] sub;
    logic             ge;
    // Divide: acc is the partial remainder, opa shifts the dividend out and quotient bits in
    always_comb begin
        sh    = {acc, opa[WIDTH-1]};
        ge    = sh >= {1'b0, opb};
        sub   = sh[WIDTH-1:0] - opb;
        acc_n = mul ? (opb[0] ? acc + opa : acc) : (ge ? sub : sh[WIDTH-1:0]);
        opa_n = mul ? opa << 1 : {opa[WIDTH-2:0], ge};
        opb_n = mul ? opb >> 1 : opb;
    end
endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M MUL/DIV/DIVU/REM/REMU sequencer that stalls the pipeline
// until the result is ready; one iteration per cycle, special cases finish in one cycle.
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int WIDTH = W_DEF,
    parameter int CNT_W = 6
) (
    input logic         clk_i,
    input logic         rst_i,
    muldiv_seq_if.slave bus
);
    localparam logic [WIDTH-1:0] MIN = {1'b1, {(WIDTH-1){1'b0}}};
    state_t           state, state_n;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] acc, opa, opb, res, acc_n, opa_n, opb_n;
    logic [WIDTH-1:0] mag1, mag2, q_fix, r_fix, pre;
    logic [2:0]       f3;
    logic             neg_q, neg_r, sgn, neg1, neg2, special, is_mul, go;
    assign sgn    = bus.func3_i == F3_DIV || bus.func3_i == F3_REM;
    assign neg1   = sgn & bus.src1_i[WIDTH-1];
    assign neg2   = sgn & bus.src2_i[WIDTH-1];
    assign mag1   = neg1 ? -bus.src1_i : bus.src1_i;
    assign mag2   = neg2 ? -bus.src2_i : bus.src2_i;
    assign go     = state == IDLE && bus.start_i && !bus.flush_i;
    assign is_mul = f3 == F3_MUL;
    assign q_fix  = neg_q ? -opa_n : opa_n;
    assign r_fix  = neg_r ? -acc_n : acc_n;
    // Results known at request time skip CALC entirely
    always_comb begin
        special = 1'b1;
        pre     = '0;
        if (bus.func3_i == F3_MUL) special = 1'b0;
        else if (!bus.func3_i[2]) pre = '0;
        else if (bus.src2_i == '0) pre = bus.func3_i[1] ? bus.src1_i : '1;
        else if (sgn && bus.src1_i == MIN && bus.src2_i == '1) pre = bus.func3_i[1] ? '0 : MIN;
        else special = 1'b0;
    end
    muldiv_core #(.WIDTH(WIDTH)) core (
        .mul(is_mul), .acc(acc), .opa(opa), .opb(opb),
        .acc_n(acc_n), .opa_n(opa_n), .opb_n(opb_n)
    );
    always_ff @(posedge clk_i or negedge rst_i)
        if (!rst_i) state <= IDLE;
        else state <= state_n;
    always_comb begin
        state_n      = IDLE;
        bus.busy_o   = state != IDLE;
        bus.stall_o  = state == CALC || (state == IDLE && bus.start_i);
        bus.done_o   = state == DONE && !bus.flush_i;
        bus.result_o = res;
        case (state)
            IDLE:    state_n = !go ? IDLE : special ? DONE : CALC;
            CALC:    state_n = bus.flush_i ? IDLE : cnt == CNT_W'(1) ? DONE : CALC;
            default: state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt   <= '0;
            acc   <= '0;
            opa   <= '0;
            opb   <= '0;
            res   <= '0;
            f3    <= '0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (go) begin
            f3    <= bus.func3_i;
            neg_q <= neg1 ^ neg2;
            neg_r <= neg1;
            acc   <= '0;
            opa   <= mag1;
            opb   <= mag2;
            cnt   <= CNT_W'(WIDTH);
            if (special) res <= pre;
        end else if (state == CALC && !bus.flush_i) begin
            acc <= acc_n;
            opa <= opa_n;
            opb <= opb_n;
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) res <= is_mul ? acc_n : f3[1] ? r_fix : q_fix;
        end
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: scenario tasks with a result scoreboard for the multiply/divide sequencer
module tb_muldiv_seq;
    import muldiv_seq_pkg::*;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int passed = 0;
    int total = 0;
    logic [31:0] sb[$];
    muldiv_seq_if bus();
    muldiv_seq dut (.clk_i(clk), .rst_i(rst), .bus(bus));
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input bit push, input logic [31:0] exp, output logic st0);
        bus.func3_i = f3;
        bus.src1_i  = a;
        bus.src2_i  = b;
        bus.start_i = 1'b1;
        if (push) sb.push_back(exp);
        #1 st0 = bus.stall_o;
        @(posedge clk);
        #1 bus.start_i = 1'b0;
    endtask

    task automatic wait_done(output int lat, output logic [31:0] res);
        lat = -1;
        res = 'x;
        for (int c = 1; c <= 100 && lat < 0; c++) begin
            #1;
            if (bus.done_o) begin
                lat = c;
                res = bus.result_o;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        bus.start_i = 1'b0;
        bus.flush_i = 1'b0;
        bus.func3_i = '0;
        bus.src1_i  = '0;
        bus.src2_i  = '0;
        #12;
        total++; if (bus.busy_o !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy_o); else passed++;
        total++; if (bus.done_o !== 1'b0) $display("FAIL reset_done: got %b want 0", bus.done_o); else passed++;
        total++; if (bus.stall_o !== 1'b0) $display("FAIL reset_stall: got %b want 0", bus.stall_o); else passed++;
        total++; if (bus.result_o !== 32'h0) $display("FAIL reset_result: got %h want 0", bus.result_o); else passed++;
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_mul();
        logic st0;
        logic [31:0] e;
        issue(F3_MUL, 32'h7, 32'hFFFF_FFFD, 1, 32'hFFFF_FFEB, st0);
        total++; if (st0 !== 1'b1) $display("FAIL mul_stall_c0: got %b want 1", st0); else passed++;
        for (int c = 1; c <= 33; c++) begin
            #1;
            total++;
            if (bus.stall_o !== (c <= 32)) $display("FAIL mul_stall_c%0d: got %b want %b", c, bus.stall_o, c <= 32);
            else passed++;
            total++;
            if (bus.done_o !== (c == 33)) $display("FAIL mul_done_c%0d: got %b want %b", c, bus.done_o, c == 33);
            else passed++;
            if (c == 33) begin
                e = sb.pop_front();
                total++; if (bus.result_o !== e) $display("FAIL mul_result: got %h want %h", bus.result_o, e); else passed++;
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_div();
        logic [2:0]  f3s[3] = '{F3_DIV, F3_REM, F3_DIVU};
        logic [31:0] as[3]  = '{32'hFFFF_FFEC, 32'hFFFF_FFEC, 32'hFFFF_FFFF};
        logic [31:0] bs[3]  = '{32'h6, 32'h6, 32'h2};
        logic [31:0] es[3]  = '{32'hFFFF_FFFD, 32'hFFFF_FFFE, 32'h7FFF_FFFF};
        logic st0;
        logic [31:0] res, e;
        int lat;
        for (int i = 0; i < 3; i++) begin
            issue(f3s[i], as[i], bs[i], 1, es[i], st0);
            wait_done(lat, res);
            e = sb.pop_front();
            total++; if (res !== e) $display("FAIL div%0d_result: got %h want %h", i, res, e); else passed++;
            total++; if (lat != 33) $display("FAIL div%0d_latency: got %0d want 33", i, lat); else passed++;
        end
    endtask

    task automatic test_special();
        logic [2:0]  f3s[7] = '{F3_DIVU, F3_REMU, F3_DIV, F3_REM, F3_DIV, F3_REM, 3'b010};
        logic [31:0] as[7]  = '{32'h5, 32'h5, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'h9};
        logic [31:0] bs[7]  = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h3};
        logic [31:0] es[7]  = '{32'hFFFF_FFFF, 32'h5, 32'h8000_0000, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'h0};
        logic st0;
        logic [31:0] res, e;
        int lat;
        for (int i = 0; i < 7; i++) begin
            issue(f3s[i], as[i], bs[i], 1, es[i], st0);
            wait_done(lat, res);
            e = sb.pop_front();
            total++; if (res !== e) $display("FAIL special%0d_result: got %h want %h", i, res, e); else passed++;
            total++; if (lat != 1) $display("FAIL special%0d_latency: got %0d want 1", i, lat); else passed++;
        end
    endtask

    task automatic test_flush();
        logic st0;
        logic [31:0] res, e;
        int lat;
        issue(F3_DIV, 32'd100, 32'd7, 0, 32'h0, st0);
        repeat (9) begin @(posedge clk); #1; end
        bus.flush_i = 1'b1;
        #1;
        total++; if (bus.busy_o !== 1'b1) $display("FAIL flush_calc_busy: got %b want 1", bus.busy_o); else passed++;
        @(posedge clk);
        #1 bus.flush_i = 1'b0;
        #1;
        total++; if (bus.busy_o !== 1'b0) $display("FAIL flush_calc_idle: got %b want 0", bus.busy_o); else passed++;
        issue(F3_MUL, 32'd3, 32'd4, 1, 32'd12, st0);
        wait_done(lat, res);
        e = sb.pop_front();
        total++; if (res !== e) $display("FAIL flush_next_result: got %h want %h", res, e); else passed++;
        total++; if (lat != 33) $display("FAIL flush_next_latency: got %0d want 33", lat); else passed++;
        issue(F3_MUL, 32'd2, 32'd3, 0, 32'h0, st0);
        repeat (32) begin @(posedge clk); #1; end
        bus.flush_i = 1'b1;
        #1;
        total++; if (bus.done_o !== 1'b0) $display("FAIL flush_done_pulse: got %b want 0", bus.done_o); else passed++;
        total++; if (bus.busy_o !== 1'b1) $display("FAIL flush_done_busy: got %b want 1", bus.busy_o); else passed++;
        @(posedge clk);
        #1 bus.flush_i = 1'b0;
        bus.func3_i = F3_MUL;
        bus.start_i = 1'b1;
        bus.flush_i = 1'b1;
        @(posedge clk);
        #1 bus.start_i = 1'b0;
        bus.flush_i = 1'b0;
        #1;
        total++; if (bus.busy_o !== 1'b0) $display("FAIL flush_priority: got busy %b want 0", bus.busy_o); else passed++;
    endtask

    task automatic test_busy_start();
        logic st0;
        logic [31:0] res, e;
        int lat;
        issue(F3_MUL, 32'd3, 32'd4, 1, 32'd12, st0);
        repeat (4) begin @(posedge clk); #1; end
        bus.func3_i = F3_DIVU;
        bus.src1_i  = 32'd99;
        bus.src2_i  = 32'd1;
        bus.start_i = 1'b1;
        @(posedge clk);
        #1 bus.start_i = 1'b0;
        wait_done(lat, res);
        e = sb.pop_front();
        total++; if (res !== e) $display("FAIL busy_start_result: got %h want %h", res, e); else passed++;
        total++; if (lat + 5 != 33) $display("FAIL busy_start_latency: got %0d want 33", lat + 5); else passed++;
    endtask

    task automatic test_back_to_back();
        int dc[2] = '{-1, -1};
        int n = 0;
        logic [31:0] e;
        bus.func3_i = F3_MUL;
        bus.src1_i  = 32'd5;
        bus.src2_i  = 32'd6;
        bus.start_i = 1'b1;
        sb.push_back(32'd30);
        sb.push_back(32'd30);
        for (int c = 0; c < 120 && n < 2; c++) begin
            #1;
            if (bus.done_o) begin
                e = sb.pop_front();
                total++; if (bus.result_o !== e) $display("FAIL b2b%0d_result: got %h want %h", n, bus.result_o, e); else passed++;
                dc[n] = c;
                n++;
                if (n == 2) bus.start_i = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        bus.start_i = 1'b0;
        total++; if (dc[0] != 33) $display("FAIL b2b_first_done: got cycle %0d want 33", dc[0]); else passed++;
        total++; if (dc[1] != 67) $display("FAIL b2b_second_done: got cycle %0d want 67", dc[1]); else passed++;
    endtask

    task automatic test_async_reset();
        logic st0;
        logic [31:0] res, e;
        int lat;
        issue(F3_DIV, 32'hFFFF_FFEC, 32'd6, 0, 32'h0, st0);
        repeat (5) begin @(posedge clk); #1; end
        total++; if (bus.busy_o !== 1'b1) $display("FAIL arst_pre_busy: got %b want 1", bus.busy_o); else passed++;
        #3 rst = 1'b0;
        #1;
        total++; if (bus.busy_o !== 1'b0) $display("FAIL arst_busy: got %b want 0", bus.busy_o); else passed++;
        total++; if (bus.done_o !== 1'b0) $display("FAIL arst_done: got %b want 0", bus.done_o); else passed++;
        total++; if (bus.result_o !== 32'h0) $display("FAIL arst_result: got %h want 0", bus.result_o); else passed++;
        total++; if (bus.stall_o !== 1'b0) $display("FAIL arst_stall: got %b want 0", bus.stall_o); else passed++;
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        issue(F3_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 32'h1, st0);
        wait_done(lat, res);
        e = sb.pop_front();
        total++; if (res !== e) $display("FAIL arst_recover_result: got %h want %h", res, e); else passed++;
        total++; if (lat != 33) $display("FAIL arst_recover_latency: got %0d want 33", lat); else passed++;
    endtask

    initial begin
        test_reset();
        test_mul();
        test_div();
        test_special();
        test_flush();
        test_busy_start();
        test_back_to_back();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
